l1_l2_arb: RTL and testbench
============================

Name: l1_l2_arb

Overview:
- Arbiter and sequencer for the single L2 line port shared by the L1 instruction cache refill path and the L1 data cache refill/writeback path.
- Accepts whole-line read requests from imem and line read/write requests from dmem, then grants one at a time using round-robin.
- Holds the grant until L2 signals completion, then routes data and the valid strobe back to the owner.
- Includes an optional completion watchdog.

Parameters:
- LINE_W, 256, cache line width in bits; must equal the L1 line width.
- ADDR_W, 59, block address width (line-aligned address, offset bits stripped).
- TIMEOUT, 0, max cycles in a grant state without l2_dv; 0 disables the watchdog.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- i_addr  in  ADDR_W  imem block address.
- i_rd  in  1  imem line read request; held high until i_dv.
- i_data  out  LINE_W  line returned to imem.
- i_dv  out  1  one-cycle strobe, i_data valid.
- d_addr  in  ADDR_W  dmem block address.
- d_rd  in  1  dmem line read request; held until d_dv.
- d_wr  in  1  dmem line writeback request; held until d_dv.
- d_wdata  in  LINE_W  writeback line.
- d_data  out  LINE_W  line returned to dmem.
- d_dv  out  1  one-cycle strobe: read data valid, or write acknowledged.
- l2_addr  out  ADDR_W  latched block address of the granted transaction.
- l2_rd  out  1  L2 read strobe.
- l2_wr  out  1  L2 write strobe.
- l2_wdata  out  LINE_W  latched write line.
- l2_data  in  LINE_W  L2 read data.
- l2_dv  in  1  L2 completion strobe.
- gnt  out  2  current owner: 2'b01 = imem, 2'b10 = dmem, 2'b00 = idle.
- err_to  out  1  one-cycle pulse on watchdog expiry.

Behaviour:
- FSM states: S_IDLE, S_GNT_I, S_GNT_D. Reset puts the FSM in S_IDLE with last_gnt = D, wd_cnt = 0, l2_addr = 0, l2_wdata = 0.
- Reset values of outputs: i_dv = d_dv = l2_rd = l2_wr = err_to = 0, gnt = 0.
- d_req = d_rd | d_wr.
- S_IDLE, single requester: if only i_rd, go to S_GNT_I; if only d_req, go to S_GNT_D.
- S_IDLE, both requesting: go to the requester that is not last_gnt, so the first tie after reset goes to imem.
- On the grant edge: latch the address into l2_addr. For dmem, also latch d_wdata and is_wr = d_wr.
- d_rd and d_wr both high is illegal; treat it as a write.
- While in S_GNT_I: l2_rd = 1.
- While in S_GNT_D: l2_wr = is_wr and l2_rd = ~is_wr.
- All l2_* outputs are decoded from registers only, with no combinational path from request inputs.
- l2_dv in S_GNT_x:
  - x_dv = 1 in the same cycle (combinational).
  - x_data = l2_data, passed through combinationally. x_data mirrors l2_data at all times; only x_dv qualifies it.
  - Next state is S_IDLE; last_gnt <= x.
- Latency: request seen in S_IDLE at cycle 0 gives l2_rd/l2_wr high at cycle 1. l2_dv at cycle n gives S_IDLE at n+1 and the earliest next grant at n+2. There is one mandatory idle cycle between transactions.
- Fairness: under continuous contention, grants strictly alternate I, D, I, D.
- l2_dv in S_IDLE is ignored; no x_dv is produced.
- Requester drops its request before completion: the transaction still completes downstream and x_dv still pulses. The requester is responsible for ignoring it. The latched address is not affected by input changes.
- Watchdog:
  - wd_cnt clears on entry to a grant state and increments each cycle in a grant state without l2_dv.
  - When TIMEOUT != 0 and wd_cnt == TIMEOUT-1 with no l2_dv: pulse err_to, go to S_IDLE, update last_gnt, and emit no x_dv.
  - l2_dv in the same cycle as expiry wins: normal completion, no err_to.
- Reset mid-transaction: the FSM goes to S_IDLE at the reset edge. l2_rd/l2_wr deassert from that edge. A late l2_dv is discarded.
- gnt is decoded from the state.

Test Plan:
- Single imem read: i_rd = 1, i_addr = 0x1234 at cycle 0 → l2_rd = 1, l2_addr = 0x1234 from cycle 1. l2_dv at cycle 5 with l2_data = 0xA5..A5 → i_dv = 1, i_data = 0xA5..A5 at cycle 5, l2_rd = 0 at cycle 6, d_dv never set.
- Tie after reset: i_rd and d_rd both high at cycle 0 → imem granted first. After its l2_dv at cycle n → dmem granted at n+2, gnt = 2'b10.
- Continuous contention over 6 transactions → gnt sequence 01, 10, 01, 10, 01, 10, with exactly one idle cycle (gnt = 00) between each.
- dmem writeback: d_wr = 1, d_addr = 0x40, d_wdata = 0xDEAD..BEEF → l2_wr = 1, l2_rd = 0, l2_wdata matches. Change d_wdata mid-grant → l2_wdata unchanged. l2_dv → d_dv pulse.
- TIMEOUT = 8, imem grant with no l2_dv → err_to pulse in the 8th grant cycle, state S_IDLE next, no i_dv. A pending d_rd is granted 1 cycle later.
- rst = 1 during S_GNT_D → l2_rd/l2_wr = 0 after the edge. l2_dv one cycle later produces no d_dv, and the next tie goes to imem.

Source files
------------

// File: rtl/l1_l2_arb_if.sv
// ============================================================================
// Module      : l1_l2_arb_if
// Description : Bus bundle between the L1 refill paths, the arbiter and L2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface l1_l2_arb_if #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 59
);
    // imem refill side
    logic [ADDR_W-1:0] i_addr;
    logic              i_rd;
    logic [LINE_W-1:0] i_data;
    logic              i_dv;

    // dmem refill / writeback side
    logic [ADDR_W-1:0] d_addr;
    logic              d_rd;
    logic              d_wr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_data;
    logic              d_dv;

    // L2 line port
    logic [ADDR_W-1:0] l2_addr;
    logic              l2_rd;
    logic              l2_wr;
    logic [LINE_W-1:0] l2_wdata;
    logic [LINE_W-1:0] l2_data;
    logic              l2_dv;

    // status
    logic [1:0]        gnt;
    logic              err_to;

    modport slave (
        input  i_addr, i_rd, d_addr, d_rd, d_wr, d_wdata, l2_data, l2_dv,
        output i_data, i_dv, d_data, d_dv, l2_addr, l2_rd, l2_wr, l2_wdata,
               gnt, err_to
    );

    modport master (
        output i_addr, i_rd, d_addr, d_rd, d_wr, d_wdata, l2_data, l2_dv,
        input  i_data, i_dv, d_data, d_dv, l2_addr, l2_rd, l2_wr, l2_wdata,
               gnt, err_to
    );
endinterface

`default_nettype wire

// File: rtl/l1_l2_arb.sv
// ============================================================================
// Module      : l1_l2_arb
// Description : Round-robin arbiter/sequencer sharing one L2 line port between
//               the L1 imem refill and L1 dmem refill/writeback paths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l1_l2_arb #(
    parameter int LINE_W  = 256,
    parameter int ADDR_W  = 59,
    parameter int TIMEOUT = 0
) (
    input  wire logic   clk,
    input  wire logic   rst,
    l1_l2_arb_if.slave  bus
);

    localparam int   c_WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int   c_WD_LAST = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
    localparam logic c_WD_EN   = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_GNT_I = 2'b01,
        S_GNT_D = 2'b10
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_last_d;
    logic [c_WD_W-1:0]   r_wd_cnt;
    logic [ADDR_W-1:0]   r_l2_addr;
    logic [LINE_W-1:0]   r_l2_wdata;
    logic                r_is_wr;

    logic                w_d_req;
    logic                w_take_i;
    logic                w_take_d;
    logic                w_release;
    logic                w_expire;
    logic                w_wd_hit;

    assign w_d_req  = bus.d_rd | bus.d_wr;
    assign w_wd_hit = (r_wd_cnt == c_WD_W'(c_WD_LAST));

    always_comb begin
        w_state_nxt = r_state;
        w_take_i    = 1'b0;
        w_take_d    = 1'b0;
        w_release   = 1'b0;
        w_expire    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // On a tie imem wins only if dmem owned the port last time.
                if (bus.i_rd && (!w_d_req || r_last_d)) begin
                    w_take_i    = 1'b1;
                    w_state_nxt = S_GNT_I;
                end else if (w_d_req) begin
                    w_take_d    = 1'b1;
                    w_state_nxt = S_GNT_D;
                end
            end
            S_GNT_I, S_GNT_D: begin
                if (bus.l2_dv) begin
                    w_release = 1'b1;
                end else if (c_WD_EN && w_wd_hit) begin
                    w_expire  = 1'b1;
                    w_release = 1'b1;
                end
                if (w_release) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_last_d   <= 1'b1;
            r_wd_cnt   <= '0;
            r_l2_addr  <= '0;
            r_l2_wdata <= '0;
            r_is_wr    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state != S_IDLE && !bus.l2_dv) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
            if (w_take_i) begin
                r_l2_addr <= bus.i_addr;
                r_wd_cnt  <= '0;
            end
            // Both strobes high is treated as a writeback.
            if (w_take_d) begin
                r_l2_addr  <= bus.d_addr;
                r_l2_wdata <= bus.d_wdata;
                r_is_wr    <= bus.d_wr;
                r_wd_cnt   <= '0;
            end
            if (w_release) begin
                r_last_d <= (r_state == S_GNT_D);
            end
        end
    end

    assign bus.l2_addr  = r_l2_addr;
    assign bus.l2_wdata = r_l2_wdata;
    assign bus.l2_rd    = (r_state == S_GNT_I) || ((r_state == S_GNT_D) && !r_is_wr);
    assign bus.l2_wr    = (r_state == S_GNT_D) && r_is_wr;
    assign bus.gnt      = {r_state == S_GNT_D, r_state == S_GNT_I};

    assign bus.i_data   = bus.l2_data;
    assign bus.d_data   = bus.l2_data;
    assign bus.i_dv     = (r_state == S_GNT_I) && bus.l2_dv;
    assign bus.d_dv     = (r_state == S_GNT_D) && bus.l2_dv;
    assign bus.err_to   = w_expire;

endmodule

`default_nettype wire

// File: tb/tb_l1_l2_arb.sv
// ============================================================================
// Module      : tb_l1_l2_arb
// Description : Directed self-checking bench for l1_l2_arb with a
//               transaction-level reference model compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_l1_l2_arb;

    localparam int LW = 256;
    localparam int AW = 59;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l1_l2_arb_if #(.LINE_W(LW), .ADDR_W(AW)) bus ();

    l1_l2_arb #(.LINE_W(LW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Reference model: who owns the port, what was latched, how long it has waited.
    int              m_owner = 0;
    int              m_last  = 2;
    int              m_age   = 0;
    logic [AW-1:0]   m_addr  = '0;
    logic [LW-1:0]   m_wdata = '0;
    logic            m_wr    = 1'b0;
    bit              m_known = 1'b0;

    always @(negedge clk) begin : model
        logic       exp_to;
        logic [1:0] eg;
        logic       wi;
        logic       wd;
        exp_to = (TO != 0) && (m_owner != 0) && (m_age == TO - 1) && !bus.l2_dv;
        eg     = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
        if (m_known) begin
            chk("m_gnt",      LW'(bus.gnt),      LW'(eg));
            chk("m_l2_rd",    LW'(bus.l2_rd),    LW'((m_owner == 1) || (m_owner == 2 && !m_wr)));
            chk("m_l2_wr",    LW'(bus.l2_wr),    LW'(m_owner == 2 && m_wr));
            chk("m_l2_addr",  LW'(bus.l2_addr),  LW'(m_addr));
            chk("m_l2_wdata", bus.l2_wdata,      m_wdata);
            chk("m_i_dv",     LW'(bus.i_dv),     LW'(m_owner == 1 && bus.l2_dv));
            chk("m_d_dv",     LW'(bus.d_dv),     LW'(m_owner == 2 && bus.l2_dv));
            chk("m_err_to",   LW'(bus.err_to),   LW'(exp_to));
            chk("m_i_data",   bus.i_data,        bus.l2_data);
            chk("m_d_data",   bus.d_data,        bus.l2_data);
        end
        if (rst) begin
            m_owner = 0;
            m_last  = 2;
            m_age   = 0;
            m_addr  = '0;
            m_wdata = '0;
            m_wr    = 1'b0;
            m_known = 1'b1;
        end else if (m_known) begin
            if (m_owner != 0) begin
                if (bus.l2_dv || exp_to) begin
                    m_last  = m_owner;
                    m_owner = 0;
                end else begin
                    m_age++;
                end
            end else begin
                wi = bus.i_rd;
                wd = bus.d_rd | bus.d_wr;
                if (wi && wd)  m_owner = (m_last == 1) ? 2 : 1;
                else if (wi)   m_owner = 1;
                else if (wd)   m_owner = 2;
                if (m_owner == 1) begin
                    m_addr = bus.i_addr;
                end else if (m_owner == 2) begin
                    m_addr  = bus.d_addr;
                    m_wdata = bus.d_wdata;
                    m_wr    = bus.d_wr;
                end
                m_age = 0;
            end
        end
    end

    logic [1:0]    exp_seq [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    logic [LW-1:0] wb;
    logic [LW-1:0] a5;
    int            idle;

    initial begin
        wb = {8{32'hDEADBEEF}};
        a5 = {32{8'hA5}};
        bus.i_addr  = '0;
        bus.i_rd    = 1'b0;
        bus.d_addr  = '0;
        bus.d_rd    = 1'b0;
        bus.d_wr    = 1'b0;
        bus.d_wdata = '0;
        bus.l2_data = '0;
        bus.l2_dv   = 1'b0;

        cyc();
        cyc();
        rst = 1'b0;
        smp();
        chk("rst_gnt",    LW'(bus.gnt),     LW'(2'b00));
        chk("rst_l2_rd",  LW'(bus.l2_rd),   LW'(1'b0));
        chk("rst_l2_wr",  LW'(bus.l2_wr),   LW'(1'b0));
        chk("rst_err_to", LW'(bus.err_to),  LW'(1'b0));
        chk("rst_l2_addr", LW'(bus.l2_addr), LW'(0));
        chk("rst_l2_wdata", bus.l2_wdata,   LW'(0));

        // Single imem read: cycle 0 request, completion at cycle 5.
        bus.i_rd   = 1'b1;
        bus.i_addr = AW'(59'h1234);
        cyc();
        smp();
        chk("t1_l2_rd",   LW'(bus.l2_rd),   LW'(1'b1));
        chk("t1_l2_addr", LW'(bus.l2_addr), LW'(59'h1234));
        chk("t1_gnt",     LW'(bus.gnt),     LW'(2'b01));
        cyc(); cyc(); cyc();
        cyc();
        bus.l2_dv   = 1'b1;
        bus.l2_data = a5;
        smp();
        chk("t1_i_dv",   LW'(bus.i_dv), LW'(1'b1));
        chk("t1_i_data", bus.i_data,    a5);
        chk("t1_d_dv",   LW'(bus.d_dv), LW'(1'b0));
        cyc();
        bus.l2_dv = 1'b0;
        bus.i_rd  = 1'b0;
        smp();
        chk("t1_l2_rd_off", LW'(bus.l2_rd), LW'(1'b0));

        // Tie straight after reset goes to imem, dmem two cycles after completion.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.i_rd   = 1'b1;
        bus.d_rd   = 1'b1;
        bus.i_addr = AW'(59'h100);
        bus.d_addr = AW'(59'h200);
        cyc();
        smp();
        chk("t2_gnt_i", LW'(bus.gnt),     LW'(2'b01));
        chk("t2_addr_i", LW'(bus.l2_addr), LW'(59'h100));
        cyc();
        bus.l2_dv   = 1'b1;
        bus.l2_data = ~a5;
        smp();
        chk("t2_i_dv", LW'(bus.i_dv), LW'(1'b1));
        cyc();
        bus.l2_dv = 1'b0;
        bus.i_rd  = 1'b0;
        smp();
        chk("t2_idle", LW'(bus.gnt), LW'(2'b00));
        cyc();
        smp();
        chk("t2_gnt_d",  LW'(bus.gnt),     LW'(2'b10));
        chk("t2_addr_d", LW'(bus.l2_addr), LW'(59'h200));
        cyc();
        bus.l2_dv = 1'b1;
        smp();
        chk("t2_d_dv", LW'(bus.d_dv), LW'(1'b1));
        cyc();
        bus.l2_dv = 1'b0;
        bus.d_rd  = 1'b0;

        // Continuous contention: alternation with a single idle gap each time.
        bus.i_rd = 1'b1;
        bus.d_rd = 1'b1;
        for (int t = 0; t < 6; t++) begin
            idle = 0;
            smp();
            while (bus.gnt == 2'b00 && idle < 10) begin
                idle++;
                cyc();
                smp();
            end
            chk("t3_seq_gnt", LW'(bus.gnt), LW'(exp_seq[t]));
            if (t > 0) chk("t3_gap", LW'(idle), LW'(1));
            cyc();
            bus.l2_dv   = 1'b1;
            bus.l2_data = LW'(t + 1);
            smp();
            cyc();
            bus.l2_dv = 1'b0;
        end
        bus.i_rd = 1'b0;
        bus.d_rd = 1'b0;

        // dmem writeback with the source line changing mid-grant.
        bus.d_wr    = 1'b1;
        bus.d_addr  = AW'(59'h40);
        bus.d_wdata = wb;
        cyc();
        smp();
        chk("t4_l2_wr",    LW'(bus.l2_wr),   LW'(1'b1));
        chk("t4_l2_rd",    LW'(bus.l2_rd),   LW'(1'b0));
        chk("t4_l2_addr",  LW'(bus.l2_addr), LW'(59'h40));
        chk("t4_l2_wdata", bus.l2_wdata,     wb);
        cyc();
        bus.d_wdata = ~wb;
        smp();
        chk("t4_wdata_hold", bus.l2_wdata, wb);
        cyc();
        bus.l2_dv = 1'b1;
        smp();
        chk("t4_d_dv", LW'(bus.d_dv), LW'(1'b1));
        chk("t4_i_dv", LW'(bus.i_dv), LW'(1'b0));
        cyc();
        bus.l2_dv = 1'b0;
        bus.d_wr  = 1'b0;
        // Stray completion while idle.
        cyc();
        bus.l2_dv = 1'b1;
        smp();
        chk("t4_idle_dv_d", LW'(bus.d_dv), LW'(1'b0));
        chk("t4_idle_dv_i", LW'(bus.i_dv), LW'(1'b0));
        cyc();
        bus.l2_dv = 1'b0;
        // Read and write together behave as a write.
        bus.d_rd    = 1'b1;
        bus.d_wr    = 1'b1;
        bus.d_wdata = wb;
        cyc();
        smp();
        chk("t4_both_wr", LW'(bus.l2_wr), LW'(1'b1));
        chk("t4_both_rd", LW'(bus.l2_rd), LW'(1'b0));
        cyc();
        bus.l2_dv = 1'b1;
        cyc();
        bus.l2_dv = 1'b0;
        bus.d_rd  = 1'b0;
        bus.d_wr  = 1'b0;

        // Watchdog expiry on an imem grant with dmem waiting.
        bus.i_rd   = 1'b1;
        bus.d_rd   = 1'b1;
        bus.i_addr = AW'(59'h77);
        bus.d_addr = AW'(59'h88);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            smp();
            chk("t5_err_to", LW'(bus.err_to), LW'(k == 8));
            chk("t5_i_dv",   LW'(bus.i_dv),   LW'(1'b0));
        end
        cyc();
        bus.i_rd = 1'b0;
        smp();
        chk("t5_idle", LW'(bus.gnt), LW'(2'b00));
        cyc();
        smp();
        chk("t5_gnt_d",  LW'(bus.gnt),     LW'(2'b10));
        chk("t5_addr_d", LW'(bus.l2_addr), LW'(59'h88));
        cyc();
        bus.l2_dv = 1'b1;
        cyc();
        bus.l2_dv = 1'b0;
        bus.d_rd  = 1'b0;

        // imem owns the port last, then reset interrupts a dmem grant.
        bus.i_rd = 1'b1;
        cyc();
        cyc();
        bus.l2_dv = 1'b1;
        cyc();
        bus.l2_dv = 1'b0;
        bus.i_rd  = 1'b0;
        bus.d_rd   = 1'b1;
        bus.d_addr = AW'(59'h99);
        cyc();
        smp();
        chk("t6_gnt_d", LW'(bus.gnt), LW'(2'b10));
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.l2_dv = 1'b1;
        bus.i_rd  = 1'b1;
        bus.d_rd  = 1'b1;
        smp();
        chk("t6_l2_rd", LW'(bus.l2_rd), LW'(1'b0));
        chk("t6_l2_wr", LW'(bus.l2_wr), LW'(1'b0));
        chk("t6_d_dv",  LW'(bus.d_dv),  LW'(1'b0));
        cyc();
        bus.l2_dv = 1'b0;
        smp();
        chk("t6_tie_i", LW'(bus.gnt), LW'(2'b01));
        cyc();
        bus.l2_dv = 1'b1;
        smp();
        chk("t6_i_dv", LW'(bus.i_dv), LW'(1'b1));
        cyc();
        bus.l2_dv = 1'b0;
        bus.i_rd  = 1'b0;
        bus.d_rd  = 1'b0;
        cyc();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
